// File: rtl/rv32i_types.sv
// Shared type definitions for the memory arbiter: FSM states and requester ids.
// No logic; types only.
// Imported by mem_arbiter.
package rv32i_types;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    // Requester identity, used for round-robin tie breaking
    typedef enum logic {
        A = 1'b0,
        B = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port line arbiter: instruction side (A, read-only) and data side (B) share one memory port.
// Latency: request seen in IDLE at T -> pmem command at T+1 -> resp combinationally with pmem_resp.
// Backpressure: requester holds until its resp; one mandatory IDLE cycle between transactions.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_read,
    input  logic [ADDR_WIDTH-1:0] a_address,
    output logic                  a_resp,
    output logic [LINE_WIDTH-1:0] a_rdata,

    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [LINE_WIDTH-1:0] b_wdata,
    output logic                  b_resp,
    output logic [LINE_WIDTH-1:0] b_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    arb_state_t            state;
    arb_state_t            state_next;
    req_id_t               last_served;
    logic                  grant_a;
    logic                  grant_b;
    logic                  a_req;
    logic                  b_req;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  op_write_q;

    assign a_req = a_read;
    assign b_req = b_read | b_write;

    // Memory command fields come only from the grant-time snapshot, so they
    // stay stable even if the requester changes its lines mid-transaction.
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Read data is forwarded straight through; only meaningful while resp is high.
    assign a_rdata = pmem_rdata;
    assign b_rdata = pmem_rdata;

    // State register; reset drops back to IDLE without waiting for a clock,
    // which also kills all command/resp outputs since they decode from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot the granted request and record who was served for round-robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            op_write_q  <= 1'b0;
            last_served <= A;
        end else if (grant_a) begin
            addr_q      <= a_address;
            wdata_q     <= '0;
            op_write_q  <= 1'b0;
            last_served <= A;
        end else if (grant_b) begin
            addr_q      <= b_address;
            wdata_q     <= b_wdata;
            // A simultaneous read+write from B is treated as a write.
            op_write_q  <= b_write;
            last_served <= B;
        end
    end

    // Next-state, grant and output decode.
    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        a_resp     = 1'b0;
        b_resp     = 1'b0;

        case (state)
            IDLE: begin
                // pmem_resp is deliberately ignored here (stray or abandoned responses).
                if (a_req && b_req) begin
                    if (last_served == A) begin
                        grant_b = 1'b1;
                    end else begin
                        grant_a = 1'b1;
                    end
                end else if (a_req) begin
                    grant_a = 1'b1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                end

                if (grant_a) begin
                    state_next = SERVE_A;
                end else if (grant_b) begin
                    state_next = SERVE_B;
                end
            end

            SERVE_A: begin
                pmem_read = 1'b1;
                a_resp    = pmem_resp;
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end

            SERVE_B: begin
                pmem_read  = ~op_write_q;
                pmem_write = op_write_q;
                b_resp     = pmem_resp;
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs driven 1 ns after the rising edge; outputs checked 1 ns later.
// No backpressure modelled beyond a hand-driven pmem_resp.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          a_read;
    logic [AW-1:0] a_address;
    logic          a_resp;
    logic [LW-1:0] a_rdata;
    logic          b_read;
    logic          b_write;
    logic [AW-1:0] b_address;
    logic [LW-1:0] b_wdata;
    logic          b_resp;
    logic [LW-1:0] b_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    int total;
    int bad;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_read       (a_read),
        .a_address    (a_address),
        .a_resp       (a_resp),
        .a_rdata      (a_rdata),
        .b_read       (b_read),
        .b_write      (b_write),
        .b_address    (b_address),
        .b_wdata      (b_wdata),
        .b_resp       (b_resp),
        .b_rdata      (b_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] d1;
    logic [LW-1:0] d2;
    logic [LW-1:0] a5;
    logic [AW-1:0] exp_addr;
    logic          exp_b;

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        a_read     = 1'b0;
        a_address  = '0;
        b_read     = 1'b0;
        b_write    = 1'b0;
        b_address  = '0;
        b_wdata    = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        d1 = {8{32'hDEAD_BEEF}};
        d2 = {8{32'h1234_5678}};
        a5 = {32{8'hA5}};

        // Reset state
        cyc();
        cyc();
        #1;
        chk("rst_pmem_read",  pmem_read,    0);
        chk("rst_pmem_write", pmem_write,   0);
        chk("rst_a_resp",     a_resp,       0);
        chk("rst_b_resp",     b_resp,       0);
        chk("rst_addr",       pmem_address, 0);
        chk("rst_wdata",      pmem_wdata,   0);
        rst = 1'b0;
        cyc();

        // A read alone, memory answers 3 cycles after pmem_read
        a_read    = 1'b1;
        a_address = 32'h0000_0040;
        #1;
        chk("a_T_idle_read", pmem_read, 0);
        cyc();                                  // T+1
        a_read = 1'b0;
        #1;
        chk("a_T1_read",  pmem_read,    1);
        chk("a_T1_write", pmem_write,   0);
        chk("a_T1_addr",  pmem_address, 32'h40);
        chk("a_T1_resp",  a_resp,       0);
        cyc();                                  // T+2
        chk("a_T2_read",  pmem_read, 1);
        chk("a_T2_resp",  a_resp,    0);
        cyc();                                  // T+3
        chk("a_T3_read",  pmem_read, 1);
        chk("a_T3_addr",  pmem_address, 32'h40);
        cyc();                                  // T+4
        pmem_resp  = 1'b1;
        pmem_rdata = d1;
        #1;
        chk("a_T4_resp",   a_resp,  1);
        chk("a_T4_rdata",  a_rdata, d1);
        chk("a_T4_bresp",  b_resp,  0);
        cyc();                                  // T+5
        pmem_resp = 1'b0;
        #1;
        chk("a_T5_idle_read", pmem_read, 0);
        chk("a_T5_resp",      a_resp,    0);

        // B write alone
        b_write   = 1'b1;
        b_address = 32'h0000_1000;
        b_wdata   = a5;
        cyc();
        b_write = 1'b0;
        b_wdata = '0;
        #1;
        chk("bw_write", pmem_write,   1);
        chk("bw_read",  pmem_read,    0);
        chk("bw_addr",  pmem_address, 32'h1000);
        chk("bw_wdata", pmem_wdata,   a5);
        chk("bw_aresp", a_resp,       0);
        chk("bw_bresp0", b_resp,      0);
        cyc();
        pmem_resp = 1'b1;
        #1;
        chk("bw_bresp", b_resp, 1);
        chk("bw_aresp_done", a_resp, 0);
        cyc();
        pmem_resp = 1'b0;
        #1;
        chk("bw_idle_write", pmem_write, 0);
        chk("bw_idle_bresp", b_resp,     0);

        // B address changes mid-transaction
        b_read    = 1'b1;
        b_address = 32'h100;
        cyc();
        b_read    = 1'b0;
        b_address = 32'h200;
        #1;
        chk("bc_addr1", pmem_address, 32'h100);
        chk("bc_read",  pmem_read,    1);
        cyc();
        chk("bc_addr2", pmem_address, 32'h100);
        cyc();
        pmem_resp  = 1'b1;
        pmem_rdata = d2;
        #1;
        chk("bc_addr3", pmem_address, 32'h100);
        chk("bc_bresp", b_resp,  1);
        chk("bc_rdata", b_rdata, d2);
        chk("bc_aresp", a_resp,  0);
        cyc();
        pmem_resp = 1'b0;

        // B read+write together resolves to a write
        b_read    = 1'b1;
        b_write   = 1'b1;
        b_address = 32'h300;
        cyc();
        b_read  = 1'b0;
        b_write = 1'b0;
        #1;
        chk("brw_write", pmem_write, 1);
        chk("brw_read",  pmem_read,  0);
        pmem_resp = 1'b1;
        #1;
        chk("brw_bresp", b_resp, 1);
        cyc();
        pmem_resp = 1'b0;

        // Reset between edges while serving A
        a_read    = 1'b1;
        a_address = 32'h0000_0080;
        cyc();
        a_read = 1'b0;
        #1;
        chk("rm_read_before", pmem_read, 1);
        rst = 1'b1;
        #1;
        chk("rm_read_now", pmem_read,    0);
        chk("rm_aresp",    a_resp,       0);
        chk("rm_addr",     pmem_address, 0);
        #1;
        rst = 1'b0;
        cyc();
        pmem_resp = 1'b1;                       // stray response
        #1;
        chk("rm_stray_aresp", a_resp,    0);
        chk("rm_stray_bresp", b_resp,    0);
        chk("rm_stray_read",  pmem_read, 0);
        cyc();
        pmem_resp = 1'b0;
        #1;
        chk("rm_stray_idle", pmem_read, 0);

        // Both sides held: round-robin B, A, B, A (last_served=A after reset)
        a_read    = 1'b1;
        a_address = 32'h0000_0A00;
        b_read    = 1'b1;
        b_address = 32'h0000_0B00;
        for (int i = 0; i < 4; i++) begin
            exp_b    = (i % 2 == 0);
            exp_addr = exp_b ? 32'h0000_0B00 : 32'h0000_0A00;
            cyc();
            chk($sformatf("rr%0d_addr", i), pmem_address, exp_addr);
            chk($sformatf("rr%0d_read", i), pmem_read,    1);
            pmem_resp  = 1'b1;
            pmem_rdata = d1;
            #1;
            chk($sformatf("rr%0d_aresp", i), a_resp, !exp_b);
            chk($sformatf("rr%0d_bresp", i), b_resp, exp_b);
            cyc();
            pmem_resp = 1'b0;
            #1;
            chk($sformatf("rr%0d_idle", i), pmem_read, 0);
        end
        a_read = 1'b0;
        b_read = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WIDTH, default 256, meaning cache-line data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports a_read  input  1 and a_address  input  ADDR_WIDTH, carrying the instruction-side line read request, which is read-only.
REQ-006 The block SHALL have ports a_resp  output  1 and a_rdata  output  LINE_WIDTH, carrying instruction-side completion and line data.
REQ-007 The block SHALL have ports b_read  input  1, b_write  input  1, b_address  input  ADDR_WIDTH and b_wdata  input  LINE_WIDTH, carrying the data-side line request.
REQ-008 The block SHALL have ports b_resp  output  1 and b_rdata  output  LINE_WIDTH, carrying data-side completion and line data.
REQ-009 The block SHALL have ports pmem_read  output  1, pmem_write  output  1, pmem_address  output  ADDR_WIDTH and pmem_wdata  output  LINE_WIDTH, forming the shared memory request.
REQ-010 The block SHALL have ports pmem_resp  input  1 and pmem_rdata  input  LINE_WIDTH, carrying memory completion and data.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SERVE_A and SERVE_B.
REQ-012 In IDLE, pmem_read, pmem_write, a_resp and b_resp SHALL all be 0.
REQ-013 In IDLE with only a_read=1, the FSM SHALL go to SERVE_A on the next edge.
REQ-014 In IDLE with only b_read or b_write=1, the FSM SHALL go to SERVE_B on the next edge.
REQ-015 In IDLE with both sides requesting, the FSM SHALL grant the side NOT recorded in last_served (round-robin) and SHALL update last_served on grant.
REQ-016 On the grant edge, the block SHALL latch the granted address, write data and operation type; pmem_address and pmem_wdata SHALL come from these latches and SHALL be stable for the whole SERVE state.
REQ-017 In SERVE_A, pmem_read SHALL be 1 and pmem_write SHALL be 0.
REQ-018 In SERVE_B, exactly one of pmem_read or pmem_write SHALL be 1, per the latched operation type.
REQ-019 If b_read and b_write are both 1 at grant, the operation SHALL be latched as a write.
REQ-020 When pmem_resp=1 in SERVE_X, X_resp SHALL be 1 in the same cycle, with no register in the path.
REQ-021 When pmem_resp=1 in SERVE_X, X_rdata SHALL equal pmem_rdata in that same cycle.
REQ-022 When pmem_resp=1 in SERVE_X, the FSM SHALL return to IDLE on the next edge.
REQ-023 The non-granted side's resp SHALL be 0 throughout.
REQ-024 While pmem_resp=0, the FSM SHALL remain in SERVE_X, with no timeout.
REQ-025 Requester request lines dropping or changing mid-transaction SHALL be ignored; the latched transaction SHALL complete.
REQ-026 The block SHALL insert one mandatory IDLE cycle between transactions.
REQ-027 Latency SHALL be: request visible in IDLE at cycle T -> pmem_read/pmem_write at T+1 -> resp in the cycle memory responds.
REQ-028 pmem_resp arriving in IDLE SHALL be ignored.
REQ-029 a_rdata and b_rdata SHALL be don't-care when their resp is 0; the bench SHALL not check them.

Reset
REQ-030 Asserting rst SHALL force the state to IDLE immediately, without waiting for clk.
REQ-031 Asserting rst SHALL clear pmem_read, pmem_write, a_resp and b_resp to 0 immediately.
REQ-032 Asserting rst SHALL reset the latched address and data to 0.
REQ-033 Asserting rst SHALL set last_served=A, so the first tie goes to B.
REQ-034 Reset mid-transaction SHALL abandon the transaction; no resp SHALL be generated for it, and a later pmem_resp SHALL be ignored.

Structure
REQ-035 The state enum (IDLE, SERVE_A, SERVE_B) and the requester-id enum (A, B) SHALL be defined in rv32i_types.
REQ-036 The block SHALL be a single module with no sub-module; the latches SHALL be local flops.

Verification
REQ-037 Scenario: a_read=1 at 0x0000_0040 alone, memory responds 3 cycles after pmem_read -> pmem_read=1 with pmem_address=0x40 from T+1, a_resp=1 with a_rdata=pmem_rdata at T+4, IDLE at T+5.
REQ-038 Scenario: b_write=1 at 0x0000_1000 with b_wdata=256'hA5...A5 -> pmem_write=1, pmem_wdata=A5...A5, pmem_read=0, b_resp pulse, a_resp=0 throughout.
REQ-039 Scenario: a_read and b_read held together for 4 transactions after reset -> grant order B, A, B, A, each separated by one IDLE cycle.
REQ-040 Scenario: b_address changes from 0x100 to 0x200 during SERVE_B -> pmem_address stays 0x100 until b_resp.
REQ-041 Scenario: rst pulsed mid-SERVE_A between clock edges -> pmem_read=0 immediately, a_resp never asserted, and a subsequent stray pmem_resp is ignored.
REQ-042 Scenario: b_read=b_write=1 at grant -> pmem_write=1 and pmem_read=0.
